// File: rtl/ptp_loader_if.sv
// ptp_loader_if: byte-stream and text-memory write bus of the PTP program loader.
//   rx_data/rx_valid : incoming frame bytes (host -> loader)
//   rx_ready         : loader accepts a byte; transfer when rx_valid && rx_ready
//   mem_we/mem_addr/mem_wdata : one-cycle text memory write (loader -> memory)
// master modport: host/memory side. slave modport: the loader itself.
interface ptp_loader_if #(
  parameter int AW = 16
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ptp_loader.sv
// ptp_loader: loads a framed byte stream into PTP text memory and holds the
// processor in reset until a frame with a valid checksum has been written.
// Frame: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CNT x (HI, LO), CHK.
// The 8-bit sum of every byte after SYNC (CHK included) must be 8'h00.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   bus       : rx byte stream in, text memory write strobe/address/data out
//   halt      : PTP halt flag, sampled while the processor runs
//   cpu_reset : active-high reset to PTP
//   loading   : frame in progress (SYNC accepted, CHK not yet accepted)
//   done      : last frame passed its checksum and PTP was released
//   error     : last frame failed its checksum
module ptp_loader #(
  parameter logic [7:0] SYNC = 8'hA5,
  parameter int          AW   = 16
) (
  input  logic         clk,
  input  logic         reset,
  ptp_loader_if.slave  bus,
  input  logic         halt,
  output logic         cpu_reset,
  output logic         loading,
  output logic         done,
  output logic         error
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_A_HI = 4'd1,
    S_A_LO = 4'd2,
    S_C_HI = 4'd3,
    S_C_LO = 4'd4,
    S_D_HI = 4'd5,
    S_D_LO = 4'd6,
    S_CHK  = 4'd7,
    S_RUN  = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    hi_q, hi_d;       // shared holding byte for ADDR_HI, CNT_HI and data HI
  logic [7:0]    sum_q, sum_d;
  logic          rx_ready_q, rx_ready_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          loading_q, loading_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          accept_s;
  logic [7:0]    sum_next_s;

  // Modulo-256 running checksum step.
  function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign loading       = loading_q;
  assign done          = done_q;
  assign error         = error_q;

  assign accept_s   = bus.rx_valid && rx_ready_q;
  assign sum_next_s = sum_add(sum_q, bus.rx_data);

  // Next-state and next-output computation for the frame parser.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    loading_d   = loading_q;
    done_d      = done_q;
    error_d     = error_q;

    if (state_q == S_RUN) begin
      // rx_ready is low here, so only halt can move the FSM.
      if (halt) begin
        state_d     = S_IDLE;
        cpu_reset_d = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else if (accept_s) begin
      // Every byte after SYNC contributes to the checksum.
      if (state_q != S_IDLE) begin
        sum_d = sum_next_s;
      end else begin
        sum_d = sum_q;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.rx_data == SYNC) begin
            sum_d     = 8'h00;
            done_d    = 1'b0;
            error_d   = 1'b0;
            loading_d = 1'b1;
            state_d   = S_A_HI;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_A_HI: begin
          hi_d    = bus.rx_data;
          state_d = S_A_LO;
        end
        S_A_LO: begin
          addr_d  = AW'({hi_q, bus.rx_data});
          state_d = S_C_HI;
        end
        S_C_HI: begin
          hi_d    = bus.rx_data;
          state_d = S_C_LO;
        end
        S_C_LO: begin
          cnt_d = {hi_q, bus.rx_data};
          if ({hi_q, bus.rx_data} == 16'h0000) begin
            state_d = S_CHK;
          end else begin
            state_d = S_D_HI;
          end
        end
        S_D_HI: begin
          hi_d    = bus.rx_data;
          state_d = S_D_LO;
        end
        S_D_LO: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = {hi_q, bus.rx_data};
          addr_d      = addr_q + AW'(1);   // wraps at the top of the address space
          cnt_d       = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = S_CHK;
          end else begin
            state_d = S_D_HI;
          end
        end
        S_CHK: begin
          loading_d = 1'b0;
          if (sum_next_s == 8'h00) begin
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_RUN;
          end else begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    rx_ready_d = (state_d != S_RUN);
  end

  // State and registered outputs; reset aborts any frame and re-holds PTP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= {AW{1'b0}};
      cnt_q       <= 16'h0000;
      hi_q        <= 8'h00;
      sum_q       <= 8'h00;
      rx_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= 16'h0000;
      cpu_reset_q <= 1'b1;
      loading_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      sum_q       <= sum_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      loading_q   <= loading_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_ptp_loader.sv
// tb_ptp_loader: directed self-checking bench for ptp_loader.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ptp_loader;

  logic clk;
  logic reset;
  logic halt;
  logic cpu_reset;
  logic loading;
  logic done;
  logic error;

  int checks;
  int errors;
  int cyc;

  logic [7:0]  frame_q[$];
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          wr_cyc_q[$];

  ptp_loader_if #(.AW(16)) bus ();

  ptp_loader #(.SYNC(8'hA5), .AW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .halt      (halt),
    .cpu_reset (cpu_reset),
    .loading   (loading),
    .done      (done),
    .error     (error)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter for write spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle in which the write strobe is high.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  // Send frame_q starting at a falling edge; optionally idle a cycle between bytes.
  task automatic send_frame(input bit throttle);
    foreach (frame_q[i]) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = frame_q[i];
      @(negedge clk);
      if (throttle) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
      end
    end
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic check_two_writes(input string tag, input logic [15:0] a0, input logic [15:0] d0,
                                  input logic [15:0] a1, input logic [15:0] d1, input int gap);
    check_val({tag, "_nwr"}, wr_addr_q.size(), 2);
    if (wr_addr_q.size() >= 2) begin
      check_val({tag, "_a0"}, wr_addr_q[0], a0);
      check_val({tag, "_d0"}, wr_data_q[0], d0);
      check_val({tag, "_a1"}, wr_addr_q[1], a1);
      check_val({tag, "_d1"}, wr_data_q[1], d1);
      check_val({tag, "_gap"}, wr_cyc_q[1] - wr_cyc_q[0], gap);
    end
  endtask

  task automatic check_released(input string tag);
    check_val({tag, "_cpu_reset"}, cpu_reset, 1'b0);
    check_val({tag, "_done"}, done, 1'b1);
    check_val({tag, "_error"}, error, 1'b0);
    check_val({tag, "_loading"}, loading, 1'b0);
    check_val({tag, "_rx_ready"}, bus.rx_ready, 1'b0);
  endtask

  // Raise halt for one sampling edge and check PTP is re-held.
  task automatic do_halt(input string tag);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check_val({tag, "_halt_cpu_reset"}, cpu_reset, 1'b1);
    check_val({tag, "_halt_rx_ready"}, bus.rx_ready, 1'b1);
    check_val({tag, "_halt_done"}, done, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_cpu_reset"}, cpu_reset, 1'b1);
    check_val({tag, "_rx_ready"}, bus.rx_ready, 1'b1);
    check_val({tag, "_mem_we"}, bus.mem_we, 1'b0);
    check_val({tag, "_mem_addr"}, bus.mem_addr, 16'h0000);
    check_val({tag, "_mem_wdata"}, bus.mem_wdata, 16'h0000);
    check_val({tag, "_loading"}, loading, 1'b0);
    check_val({tag, "_done"}, done, 1'b0);
    check_val({tag, "_error"}, error, 1'b0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    reset        = 1'b0;
    halt         = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    @(negedge clk);

    // Noise before SYNC is ignored.
    clear_writes();
    frame_q = '{8'h00, 8'hFF, 8'h12};
    send_frame(1'b0);
    @(negedge clk);
    check_val("noise_loading", loading, 1'b0);
    check_val("noise_cpu_reset", cpu_reset, 1'b1);
    check_val("noise_done", done, 1'b0);
    check_val("noise_error", error, 1'b0);
    check_val("noise_nwr", wr_addr_q.size(), 0);

    // Basic load, back to back.
    clear_writes();
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h30};
    send_frame(1'b0);
    check_released("basic");
    check_two_writes("basic", 16'h0010, 16'h1234, 16'h0011, 16'hABCD, 2);
    do_halt("basic");

    // Bad checksum: writes happen, error set, PTP stays held.
    clear_writes();
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h31};
    send_frame(1'b0);
    check_val("bad_error", error, 1'b1);
    check_val("bad_done", done, 1'b0);
    check_val("bad_cpu_reset", cpu_reset, 1'b1);
    check_val("bad_loading", loading, 1'b0);
    check_val("bad_rx_ready", bus.rx_ready, 1'b1);
    check_two_writes("bad", 16'h0010, 16'h1234, 16'h0011, 16'hABCD, 2);

    // A correct frame clears error.
    clear_writes();
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h30};
    send_frame(1'b0);
    check_released("recover");
    do_halt("recover");

    // Empty frame: no writes, PTP released.
    clear_writes();
    frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    check_released("empty");
    check_val("empty_nwr", wr_addr_q.size(), 0);
    do_halt("empty");

    // Address wrap FFFF -> 0000.
    clear_writes();
    frame_q = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFD};
    send_frame(1'b0);
    check_released("wrap");
    check_two_writes("wrap", 16'hFFFF, 16'h0001, 16'h0000, 16'h0002, 2);
    do_halt("wrap");

    // Throttled basic load: same writes, one idle cycle between bytes.
    clear_writes();
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h30};
    send_frame(1'b1);
    check_released("thr");
    check_two_writes("thr", 16'h0010, 16'h1234, 16'h0011, 16'hABCD, 4);
    do_halt("thr");

    // Reset pulsed after the first data byte aborts the frame.
    clear_writes();
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12};
    send_frame(1'b0);
    check_val("mid_loading", loading, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_writes();
    frame_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h30};
    send_frame(1'b0);
    check_released("after_rst");
    check_two_writes("after_rst", 16'h0010, 16'h1234, 16'h0011, 16'hABCD, 2);
    do_halt("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptp_loader.md
# ptp_loader

Hardware program loader for the Pipelined Tangled Processor (PTP): receives a framed byte stream, writes 16-bit instruction words into PTP text memory, and holds the processor in reset until a frame with a valid checksum has been loaded. It is the writer side of PTP instruction memory, taking over the program-loading and reset-sequencing job the simulation bench does for the processor, so PTP can run from a host link. It then watches `halt` and returns to idle.

## Interface
- `SYNC`, 8'hA5: frame start byte.
- `AW`, 16: text memory address width.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte. A transfer occurs on an edge where `rx_valid && rx_ready`.
- `halt` in 1: PTP halt flag.
- `cpu_reset` out 1: active-high reset to PTP.
- `mem_we` out 1: text memory write strobe, one cycle.
- `mem_addr` out AW: write address.
- `mem_wdata` out 16: write data.
- `loading` out 1: a frame is in progress (SYNC accepted, checksum not yet accepted).
- `done` out 1: last frame passed its checksum and PTP was released.
- `error` out 1: last frame failed its checksum.

## Operation
- Frame format: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words (each HI byte then LO byte), then CHK. All fields are big-endian.
- Checksum: the 8-bit modulo-256 sum of every byte after SYNC, including CHK, must equal 8'h00.
- States:
  - IDLE: bytes other than SYNC are discarded. Accepting SYNC clears `done`/`error`, clears the running sum, sets `loading`, and moves to A_HI.
  - A_HI → A_LO → C_HI → C_LO: load the address and count registers.
  - After C_LO: go to D_HI if CNT≠0, otherwise go to CHK.
  - D_HI: latch the high byte.
  - D_LO: issue the write, decrement the count, and increment the address.
    - Address increment wraps mod 2^AW (FFFF → 0000).
    - Go to D_HI while the remaining count is ≠0, otherwise go to CHK.
  - CHK:
    - Sum == 0: go to RUN, with `cpu_reset`=0 and `done`=1.
    - Otherwise: go to IDLE, with `error`=1 and `cpu_reset` still 1.
    - `loading` clears in both cases.
  - RUN: `rx_ready`=0. When `halt`=1 is sampled: go to IDLE and set `cpu_reset`=1. `done` stays set.
- `rx_ready`=1 in every state except RUN.
- Writes made before a failed checksum are not undone. Memory contents after a failed frame are undefined to software.
- CNT=65535 is legal. Full wrap of the address space is allowed.

## Timing
- Reset values while `reset`=0: state IDLE, `cpu_reset`=1, `rx_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `loading`=0, `done`=0, `error`=0.
- Reset is asynchronous. Asserting it mid-frame or in RUN takes effect immediately, aborts the frame, and reasserts `cpu_reset`.
- `mem_we` is registered. It is high for exactly the one cycle after the edge that accepts a D_LO byte, with `mem_addr`/`mem_wdata` valid in that same cycle.
- Back-to-back bytes (`rx_valid` held high) are accepted at one byte per cycle with no stalls. Sustained write rate is one word per 2 cycles.
- `cpu_reset` falls and `done` rises in the cycle after the edge that accepts CHK. `error` rises at the same point on failure.
- In RUN, `halt` is sampled on each edge. `cpu_reset` rises the cycle after `halt` is first seen high. The next SYNC can be accepted one cycle after that.
- Gaps with `rx_valid`=0 hold the state indefinitely. There is no timeout.

## Test plan
- Basic load. Stimulus: A5 00 10 00 02 12 34 AB CD 30, no gaps.
  - Required: writes mem[0010]=1234 then mem[0011]=ABCD, 2 cycles apart.
  - Then `cpu_reset` 1→0 and `done`=1 the cycle after the 30 is accepted. `error`=0.
- Bad checksum. Stimulus: the same frame with last byte 31.
  - Required: both writes occur, `error`=1, `done`=0, `cpu_reset` stays 1, state returns to IDLE.
  - A following correct frame clears `error`.
- Empty frame and wrap:
  - A5 00 00 00 00 00: no `mem_we`, PTP released.
  - A5 FF FF 00 02 00 01 00 02 FD: writes mem[FFFF]=0001 and mem[0000]=0002.
- Framing noise and throttling:
  - Bytes 00 FF 12 before SYNC are ignored with no state change.
  - `rx_valid` toggled every other cycle during a frame gives the same writes as the basic load.
- Reset and halt:
  - `reset` pulsed low after the first data byte: all outputs return to reset values, and the next full frame loads correctly.
  - In RUN, `halt`=1: `cpu_reset`=1 next cycle, `rx_ready`=1, `done` stays 1.
